input_buffer: RTL and testbench

Single-port-addressed pixel frame store for the YOLO front end. Accepts 24-bit RGB pixels at (x, y) coordinates from the capture/pre-processing stage and holds one full frame. Reading uses the same coordinates and drives a registered read port consumed by the first convolution layer's fetch logic. Also counts accepted writes so that upstream control can detect a completely loaded frame.

---
 rtl/input_buffer_if.sv | 41 ++++
 rtl/input_buffer.sv | 91 +++++++++
 tb/tb_input_buffer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/input_buffer_if.sv
// Pixel store bus: write port, coordinate-addressed registered read port and
// the write-count status seen by upstream control.
// master drives pixels/coordinates; slave is the frame store itself.
interface input_buffer_if #(
    parameter int unsigned IMG_W = 416,
    parameter int unsigned IMG_H = 416,
    parameter int unsigned PIX_W = 24
);
    localparam int unsigned CNT_W = $clog2(IMG_W * IMG_H + 1);

    logic [PIX_W-1:0] pixel_data;
    logic [10:0]      x_coord;
    logic [10:0]      y_coord;
    logic             write_enable;
    logic [PIX_W-1:0] read_data;
    logic             read_valid;
    logic [CNT_W-1:0] pixel_count;
    logic             frame_full;

    modport master (
        output pixel_data,
        output x_coord,
        output y_coord,
        output write_enable,
        input  read_data,
        input  read_valid,
        input  pixel_count,
        input  frame_full
    );

    modport slave (
        input  pixel_data,
        input  x_coord,
        input  y_coord,
        input  write_enable,
        output read_data,
        output read_valid,
        output pixel_count,
        output frame_full
    );
endinterface

// File: rtl/input_buffer.sv
// Single-frame RGB pixel store addressed by (x, y), with a one-cycle registered
// read port and a saturating count of accepted writes.
// Optional macro INPUT_BUFFER_WR_FWD_EN: when defined, a read that coincides
// with an in-range write returns the new pixel (write-first); otherwise the
// old stored word is returned (read-first).
// rst_n is a synchronous, active-HIGH reset despite its name.
module input_buffer #(
    parameter int unsigned IMG_W = 416,
    parameter int unsigned IMG_H = 416,
    parameter int unsigned PIX_W = 24
) (
    input logic           clk,
    input logic           rst_n,
    input_buffer_if.slave bus
);
    localparam int unsigned DEPTH  = IMG_W * IMG_H;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    localparam logic [11:0]      ImgWLim   = 12'(IMG_W);
    localparam logic [11:0]      ImgHLim   = 12'(IMG_H);
    localparam logic [22:0]      ImgWWide  = 23'(IMG_W);
    localparam logic [22:0]      DepthWide = 23'(DEPTH);
    localparam logic [CNT_W-1:0] FullCnt   = CNT_W'(DEPTH);

    logic [PIX_W-1:0] mem [DEPTH];

    logic [22:0]       lin_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              in_range;
    logic              wr_ok;

    logic [PIX_W-1:0] rd_data_d, rd_data_q;
    logic             rd_valid_d, rd_valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Address decode: full-width linear address, so 2047 on either axis can
    // never wrap onto a valid word.
    always_comb begin
        lin_addr = {12'b0, bus.y_coord} * ImgWWide + {12'b0, bus.x_coord};
        in_range = ({1'b0, bus.x_coord} < ImgWLim) &&
                   ({1'b0, bus.y_coord} < ImgHLim) &&
                   (lin_addr < DepthWide);
        mem_addr = lin_addr[ADDR_W-1:0];
        wr_ok    = bus.write_enable && in_range;
    end

    // Next-state for the read port and the saturating write counter.
    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = 1'b0;
        cnt_d      = cnt_q;
        if (in_range) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[mem_addr];
`ifdef INPUT_BUFFER_WR_FWD_EN
            if (bus.write_enable) begin
                rd_data_d = bus.pixel_data;
            end
`endif
        end
        if (wr_ok && (cnt_q != FullCnt)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Frame memory: not reset, and still written during a reset cycle.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[mem_addr] <= bus.pixel_data;
        end
    end

    // Output and counter registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.read_data   = rd_data_q;
    assign bus.read_valid  = rd_valid_q;
    assign bus.pixel_count = cnt_q;
    assign bus.frame_full  = (cnt_q == FullCnt);
endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer on a small 8x6 frame. A frame-level
// reference model (array of words + written flags + integer count) predicts
// every registered output one cycle after each driven step.
module tb_input_buffer;
    localparam int unsigned IMG_W = 8;
    localparam int unsigned IMG_H = 6;
    localparam int unsigned PIX_W = 24;
    localparam int          DEPTH = IMG_W * IMG_H;
`ifdef INPUT_BUFFER_WR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst_n;

    input_buffer_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) bus ();

    input_buffer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [23:0] ref_mem [DEPTH];
    bit          ref_wr  [DEPTH];
    int          ref_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check all outputs.
    task automatic step(input bit rst, input bit we, input int x, input int y,
                        input logic [23:0] d);
        bit          inr;
        int          a;
        logic [23:0] exp_d;
        bit          exp_v;
        bit          chk_d;
        rst_n            = rst;
        bus.write_enable = we;
        bus.x_coord      = 11'(x);
        bus.y_coord      = 11'(y);
        bus.pixel_data   = d;
        inr   = (x < IMG_W) && (y < IMG_H);
        a     = inr ? (y * IMG_W + x) : 0;
        exp_d = '0;
        exp_v = 1'b0;
        chk_d = 1'b1;
        if (!rst && inr) begin
            exp_v = 1'b1;
            if (we && FWD) begin
                exp_d = d;
            end else begin
                exp_d = ref_mem[a];
                chk_d = ref_wr[a];
            end
        end
        if (we && inr) begin
            ref_mem[a] = d;
            ref_wr[a]  = 1'b1;
            if (ref_cnt < DEPTH) ref_cnt++;
        end
        if (rst) ref_cnt = 0;
        @(posedge clk);
        #1;
        check("read_valid", 32'(bus.read_valid), 32'(exp_v));
        if (chk_d) check("read_data", 32'(bus.read_data), 32'(exp_d));
        check("pixel_count", 32'(bus.pixel_count), 32'(ref_cnt));
        check("frame_full", 32'(bus.frame_full), 32'(ref_cnt == DEPTH));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            ref_wr[i]  = 1'b0;
        end

        // Reset state.
        step(1, 0, 0, 0, 24'h0);
        step(1, 0, 1, 1, 24'h0);
        check("reset_count", 32'(bus.pixel_count), 32'd0);

        // Basic write then read back.
        step(0, 1, 5, 5, 24'hFFFFFF);
        step(0, 0, 5, 5, 24'h0);
        check("basic_data", 32'(bus.read_data), 32'hFFFFFF);
        check("basic_count", 32'(bus.pixel_count), 32'd1);

        // Corner addresses must not alias.
        step(0, 1, IMG_W - 1, IMG_H - 1, 24'h123456);
        step(0, 1, 0, 0, 24'hABCDEF);
        step(0, 0, IMG_W - 1, IMG_H - 1, 24'h0);
        check("corner_hi", 32'(bus.read_data), 32'h123456);
        step(0, 0, 0, 0, 24'h0);
        check("corner_lo", 32'(bus.read_data), 32'hABCDEF);

        // Out-of-range writes are dropped and read as zero/invalid.
        step(0, 1, IMG_W, 0, 24'hAAAAAA);
        step(0, 1, 0, 2047, 24'hAAAAAA);
        step(0, 1, 2047, 2047, 24'hAAAAAA);
        step(0, 0, 0, IMG_H, 24'h0);
        check("oor_count", 32'(bus.pixel_count), 32'd3);
        step(0, 0, 0, 0, 24'h0);
        check("oor_no_alias", 32'(bus.read_data), 32'hABCDEF);

        // Back-to-back writes to one address while reading it.
        step(0, 1, 3, 3, 24'h111111);
        step(0, 1, 3, 3, 24'h222222);
        check("rw_same", 32'(bus.read_data), FWD ? 32'h222222 : 32'h111111);
        step(0, 0, 3, 3, 24'h0);
        check("rw_after", 32'(bus.read_data), 32'h222222);

        // Randomized traffic, occasionally far out of range.
        for (int i = 0; i < 200; i++) begin
            step(0, bit'($urandom_range(0, 1)), $urandom_range(0, 9),
                 ($urandom_range(0, 9) == 0) ? 2047 : $urandom_range(0, 7),
                 24'($urandom));
        end

        // Fill the whole frame, then one more write to test saturation.
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                step(0, 1, x, y, 24'($urandom));
            end
        end
        step(0, 1, 0, 0, 24'h0F0F0F);
        check("sat_count", 32'(bus.pixel_count), 32'(DEPTH));
        check("sat_full", 32'(bus.frame_full), 32'd1);

        // Reset mid-frame with a write in the same cycle.
        step(1, 0, 0, 0, 24'h0);
        step(0, 1, 1, 1, 24'h010203);
        step(0, 1, 4, 2, 24'h040506);
        step(1, 1, 2, 1, 24'h5A5A5A);
        check("rst_wr_count", 32'(bus.pixel_count), 32'd0);
        check("rst_wr_data", 32'(bus.read_data), 32'd0);
        step(0, 0, 2, 1, 24'h0);
        check("rst_wr_kept", 32'(bus.read_data), 32'h5A5A5A);

        // A few more random steps after reset.
        for (int i = 0; i < 40; i++) begin
            step(0, bit'($urandom_range(0, 1)), $urandom_range(0, 8),
                 $urandom_range(0, 6), 24'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
